// File: rtl/tspi_block_swap_fifo.sv
// Word buffer between the system OBI bus and the block-swap port of tspi_host.
// Software pushes 32-bit TX words that tspi_host drains one per signal_next_write_data_i
// pulse; RX words delivered by tspi_host are stored for software to pop.
//
// Ports:
//   clk_i, rst_ni             system clock, asynchronous active-low reset
//   obi_req_i / obi_rsp_o     OBI subordinate register port (gnt always 1, rvalid 1 cycle later)
//   write_data_o              TX FIFO head (0 when empty), to tspi_host write_data_i
//   signal_next_write_data_i  pop TX head
//   read_data_i               RX word from tspi_host read_data_o
//   signal_next_read_data_i   push read_data_i into RX
//
// Register map (addr[3:2]): 0x0 TX_DATA, 0x4 RX_DATA, 0x8 STATUS, 0xC CTRL.

package tspi_block_swap_fifo_pkg;

  // Default OBI configuration: 32-bit address/data, 1-bit transaction ID.
  typedef struct packed {
    logic [31:0] addr;
    logic        we;
    logic [3:0]  be;
    logic [31:0] wdata;
    logic [0:0]  aid;
  } obi_a_chan_t;

  typedef struct packed {
    obi_a_chan_t a;
    logic        req;
  } obi_req_t;

  typedef struct packed {
    logic [31:0] rdata;
    logic [0:0]  rid;
    logic        err;
  } obi_r_chan_t;

  typedef struct packed {
    obi_r_chan_t r;
    logic        gnt;
    logic        rvalid;
  } obi_rsp_t;

endpackage

module tspi_block_swap_fifo #(
  parameter type         obi_req_t = tspi_block_swap_fifo_pkg::obi_req_t,
  parameter type         obi_rsp_t = tspi_block_swap_fifo_pkg::obi_rsp_t,
  parameter int unsigned Depth     = 8
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  obi_req_t    obi_req_i,
  output obi_rsp_t    obi_rsp_o,
  output logic [31:0] write_data_o,
  input  logic        signal_next_write_data_i,
  input  logic [31:0] read_data_i,
  input  logic        signal_next_read_data_i
);

  localparam int unsigned AW = $clog2(Depth);
  localparam int unsigned CW = AW + 1;

  localparam logic [1:0] RegTxData = 2'd0;
  localparam logic [1:0] RegRxData = 2'd1;
  localparam logic [1:0] RegStatus = 2'd2;
  localparam logic [1:0] RegCtrl   = 2'd3;

  logic [31:0]   tx_mem [Depth];
  logic [31:0]   rx_mem [Depth];
  logic [AW-1:0] tx_wptr_q, tx_wptr_d, tx_rptr_q, tx_rptr_d;
  logic [AW-1:0] rx_wptr_q, rx_wptr_d, rx_rptr_q, rx_rptr_d;
  logic [CW-1:0] tx_cnt_q, tx_cnt_d, rx_cnt_q, rx_cnt_d;
  logic          tx_underrun_q, tx_underrun_d, rx_overrun_q, rx_overrun_d;
  obi_rsp_t      rsp_q, rsp_d;

  logic       req, we;
  logic [1:0] sel;
  logic       tx_empty, tx_full, rx_empty, rx_full;
  logic       tx_push_cpu, tx_push_ok, tx_pop_ok;
  logic       rx_pop_cpu, rx_pop_ok, rx_push_ok;
  logic       ctrl_wr, flush_tx, flush_rx, clr_flags;
  logic [31:0] status;

  logic unused_obi;
  assign unused_obi = ^{obi_req_i.a.addr[31:4], obi_req_i.a.addr[1:0], obi_req_i.a.be};

  always_comb begin
    req = obi_req_i.req;
    we  = obi_req_i.a.we;
    sel = obi_req_i.a.addr[3:2];

    tx_empty = (tx_cnt_q == '0);
    tx_full  = (tx_cnt_q == CW'(Depth));
    rx_empty = (rx_cnt_q == '0);
    rx_full  = (rx_cnt_q == CW'(Depth));

    ctrl_wr   = req & we & (sel == RegCtrl);
    flush_tx  = ctrl_wr & obi_req_i.a.wdata[0];
    flush_rx  = ctrl_wr & obi_req_i.a.wdata[1];
    clr_flags = ctrl_wr & obi_req_i.a.wdata[2];

    // A pop in the same cycle frees a slot, so a push into a full FIFO still lands.
    tx_pop_ok   = signal_next_write_data_i & ~tx_empty;
    tx_push_cpu = req & we & (sel == RegTxData);
    tx_push_ok  = tx_push_cpu & (~tx_full | tx_pop_ok);

    rx_pop_cpu = req & ~we & (sel == RegRxData);
    rx_pop_ok  = rx_pop_cpu & ~rx_empty;
    rx_push_ok = signal_next_read_data_i & (~rx_full | rx_pop_ok);

    status        = '0;
    status[0]     = tx_empty;
    status[1]     = tx_full;
    status[2]     = rx_empty;
    status[3]     = rx_full;
    status[4]     = tx_underrun_q;
    status[5]     = rx_overrun_q;
    status[15:8]  = 8'(tx_cnt_q);
    status[23:16] = 8'(rx_cnt_q);
  end

  // FIFO pointer/count next state; a flush overrides any same-cycle push or pop.
  always_comb begin
    tx_wptr_d = tx_wptr_q;
    tx_rptr_d = tx_rptr_q;
    tx_cnt_d  = tx_cnt_q;
    rx_wptr_d = rx_wptr_q;
    rx_rptr_d = rx_rptr_q;
    rx_cnt_d  = rx_cnt_q;

    if (flush_tx) begin
      tx_wptr_d = '0;
      tx_rptr_d = '0;
      tx_cnt_d  = '0;
    end else begin
      if (tx_push_ok) tx_wptr_d = tx_wptr_q + AW'(1);
      if (tx_pop_ok)  tx_rptr_d = tx_rptr_q + AW'(1);
      tx_cnt_d = tx_cnt_q + CW'(tx_push_ok) - CW'(tx_pop_ok);
    end

    if (flush_rx) begin
      rx_wptr_d = '0;
      rx_rptr_d = '0;
      rx_cnt_d  = '0;
    end else begin
      if (rx_push_ok) rx_wptr_d = rx_wptr_q + AW'(1);
      if (rx_pop_ok)  rx_rptr_d = rx_rptr_q + AW'(1);
      rx_cnt_d = rx_cnt_q + CW'(rx_push_ok) - CW'(rx_pop_ok);
    end

    // New events take priority over a same-cycle clear.
    tx_underrun_d = (tx_underrun_q & ~clr_flags) |
                    (signal_next_write_data_i & tx_empty & ~flush_tx);
    rx_overrun_d  = (rx_overrun_q & ~clr_flags) |
                    (signal_next_read_data_i & ~rx_push_ok & ~flush_rx);
  end

  // Response for the current request, presented on the following cycle.
  always_comb begin
    rsp_d          = '0;
    rsp_d.rvalid   = req;
    rsp_d.r.rid    = obi_req_i.a.aid;
    if (req) begin
      case (sel)
        RegTxData: rsp_d.r.err = we ? ~tx_push_ok : 1'b1;
        RegRxData: begin
          if (we) begin
            rsp_d.r.err = 1'b1;
          end else if (rx_pop_ok) begin
            rsp_d.r.rdata = rx_mem[rx_rptr_q];
          end else begin
            rsp_d.r.err = 1'b1;
          end
        end
        RegStatus: begin
          if (we) rsp_d.r.err   = 1'b1;
          else    rsp_d.r.rdata = status;
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      tx_wptr_q     <= '0;
      tx_rptr_q     <= '0;
      tx_cnt_q      <= '0;
      rx_wptr_q     <= '0;
      rx_rptr_q     <= '0;
      rx_cnt_q      <= '0;
      tx_underrun_q <= 1'b0;
      rx_overrun_q  <= 1'b0;
      rsp_q         <= '0;
    end else begin
      tx_wptr_q     <= tx_wptr_d;
      tx_rptr_q     <= tx_rptr_d;
      tx_cnt_q      <= tx_cnt_d;
      rx_wptr_q     <= rx_wptr_d;
      rx_rptr_q     <= rx_rptr_d;
      rx_cnt_q      <= rx_cnt_d;
      tx_underrun_q <= tx_underrun_d;
      rx_overrun_q  <= rx_overrun_d;
      rsp_q         <= rsp_d;
    end
  end

  // Storage needs no reset: the counts gate every read.
  always_ff @(posedge clk_i) begin
    if (tx_push_ok && !flush_tx) tx_mem[tx_wptr_q] <= obi_req_i.a.wdata;
    if (rx_push_ok && !flush_rx) rx_mem[rx_wptr_q] <= read_data_i;
  end

  assign write_data_o = tx_empty ? 32'h0 : tx_mem[tx_rptr_q];

  always_comb begin
    obi_rsp_o     = rsp_q;
    obi_rsp_o.gnt = 1'b1;
  end

endmodule

// File: tb/tb_tspi_block_swap_fifo.sv
// Randomized + directed bench for tspi_block_swap_fifo with a queue-based reference model.
// The driver computes expected responses and pushes them to a scoreboard; a separate
// monitor pops and compares whenever a response cycle comes around.

module tb_tspi_block_swap_fifo;
  import tspi_block_swap_fifo_pkg::*;

  localparam int unsigned Depth = 8;

  logic        clk_i = 1'b0;
  logic        rst_ni = 1'b0;
  obi_req_t    obi_req;
  obi_rsp_t    obi_rsp;
  logic [31:0] write_data;
  logic        pop_tx;
  logic [31:0] rx_word;
  logic        push_rx;

  always #5 clk_i = ~clk_i;

  tspi_block_swap_fifo #(
    .Depth(Depth)
  ) dut (
    .clk_i                    (clk_i),
    .rst_ni                   (rst_ni),
    .obi_req_i                (obi_req),
    .obi_rsp_o                (obi_rsp),
    .write_data_o             (write_data),
    .signal_next_write_data_i (pop_tx),
    .read_data_i              (rx_word),
    .signal_next_read_data_i  (push_rx)
  );

  typedef struct {
    logic [31:0] rdata;
    logic        err;
    logic        rid;
  } exp_t;

  exp_t        exp_q[$];
  logic [31:0] m_tx[$];
  logic [31:0] m_rx[$];
  bit          m_under, m_over;
  int unsigned n_checks = 0;
  int unsigned n_fail   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_checks++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h at %0t", name, act, req, $time);
    end
  endtask

  task automatic model_reset();
    m_tx.delete();
    m_rx.delete();
    m_under = 0;
    m_over  = 0;
    exp_q.delete();
  endtask

  // One bus/host cycle: check the TX head, predict, then drive.
  task automatic step(input bit r, input bit w, input logic [31:0] addr, input logic [31:0] wd,
                      input bit aid, input bit pop, input bit push, input logic [31:0] rd);
    int   tx_n, rx_n;
    bit   [1:0] sel;
    bit   tx_push, rx_pop, ctrl, f_tx, f_rx, clr;
    bit   tx_pop_ok, tx_acc, rx_pop_ok, rx_acc, under_evt, over_evt;
    exp_t e;
    @(negedge clk_i);
    check("write_data_o", write_data, (m_tx.size() > 0) ? m_tx[0] : 32'h0);
    check("gnt", {31'h0, obi_rsp.gnt}, 32'h1);

    tx_n = m_tx.size();
    rx_n = m_rx.size();
    sel     = addr[3:2];
    tx_push = r && w && sel == 2'd0;
    rx_pop  = r && !w && sel == 2'd1;
    ctrl    = r && w && sel == 2'd3;
    f_tx    = ctrl && wd[0];
    f_rx    = ctrl && wd[1];
    clr     = ctrl && wd[2];
    tx_pop_ok = pop && tx_n > 0;
    tx_acc    = tx_push && (tx_n < Depth || tx_pop_ok);
    rx_pop_ok = rx_pop && rx_n > 0;
    rx_acc    = push && (rx_n < Depth || rx_pop_ok);
    under_evt = pop && tx_n == 0 && !f_tx;
    over_evt  = push && !rx_acc && !f_rx;

    e.rdata = 32'h0;
    e.err   = 1'b0;
    e.rid   = aid;
    case (sel)
      2'd0: e.err = w ? !tx_acc : 1'b1;
      2'd1: begin
        if (w) e.err = 1'b1;
        else if (rx_pop_ok) e.rdata = m_rx[0];
        else e.err = 1'b1;
      end
      2'd2: begin
        if (w) e.err = 1'b1;
        else e.rdata = {8'h0, 8'(rx_n), 8'(tx_n), 2'b00, m_over, m_under,
                        rx_n == Depth, rx_n == 0, tx_n == Depth, tx_n == 0};
      end
      default: ;
    endcase
    if (r) exp_q.push_back(e);

    if (f_tx) m_tx.delete();
    else begin
      if (tx_pop_ok) void'(m_tx.pop_front());
      if (tx_acc) m_tx.push_back(wd);
    end
    if (f_rx) m_rx.delete();
    else begin
      if (rx_pop_ok) void'(m_rx.pop_front());
      if (rx_acc) m_rx.push_back(rd);
    end
    if (clr) begin
      m_under = 0;
      m_over  = 0;
    end
    m_under = m_under | under_evt;
    m_over  = m_over | over_evt;

    obi_req.req     = r;
    obi_req.a.we    = w;
    obi_req.a.addr  = addr;
    obi_req.a.wdata = wd;
    obi_req.a.be    = 4'($urandom);
    obi_req.a.aid   = aid;
    pop_tx  = pop;
    push_rx = push;
    rx_word = rd;
  endtask

  task automatic idle();
    step(0, 0, 32'h0, 32'h0, 0, 0, 0, 32'h0);
  endtask

  task automatic wr(input logic [31:0] addr, input logic [31:0] wd);
    step(1, 1, addr, wd, 0, 0, 0, 32'h0);
  endtask

  task automatic rd(input logic [31:0] addr);
    step(1, 0, addr, 32'h0, 1, 0, 0, 32'h0);
  endtask

  // Reset lands after a request is issued but before its response cycle.
  task automatic reset_mid();
    step(1, 0, 32'h8, 32'h0, 1, 1, 1, 32'h1234_5678);
    #2;
    rst_ni = 1'b0;
    model_reset();
    obi_req = '0;
    pop_tx  = 1'b0;
    push_rx = 1'b0;
    #1;
    check("reset_write_data", write_data, 32'h0);
    @(negedge clk_i);
    @(negedge clk_i);
    rst_ni = 1'b1;
  endtask

  // Scoreboard monitor.
  always @(posedge clk_i) begin
    exp_t e;
    #1;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      check("rvalid", {31'h0, obi_rsp.rvalid}, 32'h1);
      check("rdata", obi_rsp.r.rdata, e.rdata);
      check("err", {31'h0, obi_rsp.r.err}, {31'h0, e.err});
      check("rid", {31'h0, obi_rsp.r.rid}, {31'h0, e.rid});
    end else begin
      check("rvalid_idle", {31'h0, obi_rsp.rvalid}, 32'h0);
    end
  end

  initial begin
    obi_req = '0;
    pop_tx  = 1'b0;
    push_rx = 1'b0;
    rx_word = 32'h0;
    model_reset();
    repeat (3) @(negedge clk_i);
    #1;
    check("reset_write_data", write_data, 32'h0);
    rst_ni = 1'b1;

    // Reset status.
    rd(32'h8);
    idle();

    // TX drain ordering.
    for (int i = 1; i <= 3; i++) wr(32'h0, 32'hA5A5_0000 + 32'(i));
    for (int i = 0; i < 3; i++) step(1, 0, 32'h8, 32'h0, 0, 1, 0, 32'h0);
    rd(32'h8);

    // TX full, overflow, simultaneous pop and push.
    for (int i = 0; i < 9; i++) wr(32'h0, 32'hB000_0000 + 32'(i));
    rd(32'h8);
    step(1, 1, 32'h0, 32'hC0DE_0001, 0, 1, 0, 32'h0);
    rd(32'h8);
    wr(32'hC, 32'h1);

    // RX single word, then empty pop.
    step(0, 0, 32'h0, 32'h0, 0, 0, 1, 32'hDEAD_BEEF);
    rd(32'h4);
    rd(32'h4);

    // RX fill, overrun, flush+clear.
    for (int i = 0; i < 9; i++) step(0, 0, 32'h0, 32'h0, 0, 0, 1, 32'h7000_0000 + 32'(i));
    rd(32'h8);
    wr(32'hC, 32'h6);
    rd(32'h8);

    // Underrun, then reset mid-transfer.
    step(0, 0, 32'h0, 32'h0, 0, 1, 0, 32'h0);
    rd(32'h8);
    wr(32'h0, 32'h1111_1111);
    reset_mid();
    rd(32'h8);

    // Randomized phases with varying pressure on each FIFO.
    for (int p = 0; p < 6; p++) begin
      int unsigned pop_pct  = (p % 2 == 0) ? 15 : 55;
      int unsigned push_pct = (p % 3 == 0) ? 60 : 20;
      for (int i = 0; i < 400; i++) begin
        bit          r    = $urandom_range(0, 99) < 65;
        bit          w    = $urandom_range(0, 1) == 1;
        bit [1:0]    sel  = 2'($urandom_range(0, 3));
        logic [31:0] wd   = $urandom;
        logic [31:0] addr = {$urandom} & 32'hFFFF_FFF3;
        addr[3:2] = sel;
        if (sel == 2'd3 && $urandom_range(0, 5) != 0) wd = wd & 32'hFFFF_FFF8;
        if (p == 0 && sel == 2'd1) sel = 2'd0;
        step(r, w, addr, wd, 1'($urandom), $urandom_range(0, 99) < pop_pct,
             $urandom_range(0, 99) < push_pct, $urandom);
      end
      if (p == 2) reset_mid();
    end

    idle();
    idle();
    @(negedge clk_i);
    check("scoreboard_drained", 32'(exp_q.size()), 32'h0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
